mpc_constraint_vec_port_master: RTL and testbench
=================================================

Name: mpc_constraint_vec_port_master

Overview:
- Single-port master for the dense-constraint temp-vector RAM (1R1W, read-first, 1-cycle read latency, q0 holds while ce0=0).
- Loads AddressRange fixed-point elements from an upstream valid/ready stream into the RAM.
- Replays them, in address order, as a downstream valid/ready stream to the constraint evaluator.
- Sits between the constraint-vector producer and the MPC dense constraint datapath; the RAM is instantiated alongside it, not inside it.

Parameters:
- DataWidth, 21, element width (fixed-point, opaque to this block).
- AddressWidth, 3, RAM address width.
- AddressRange, 6, number of elements per vector; 1 <= AddressRange <= 2**AddressWidth.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse: begin vector load.
- drain_start  in  1  single-cycle pulse: begin vector replay.
- in_data  in  DataWidth  upstream element.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  block accepts in_data.
- out_data  out  DataWidth  downstream element, driven directly from ram_q0.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  out_valid element is index AddressRange-1.
- loaded  out  1  RAM holds a complete vector.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  one-cycle pulse after final drain handshake.
- ram_address0  out  AddressWidth  RAM address.
- ram_ce0  out  1  RAM enable.
- ram_we0  out  1  RAM write enable.
- ram_d0  out  DataWidth  RAM write data.
- ram_q0  in  DataWidth  RAM read data.

Behaviour:
- Reset values: state IDLE; index=0; rd_pending=0; loaded=0; done=0. All outputs 0; ram_d0 is don't-care.
- Reset asserted mid-LOAD or mid-DRAIN aborts immediately. The next cycle is IDLE with loaded=0. Partial RAM contents are abandoned, not cleared.
- States: IDLE, LOAD, LOADED, DRAIN.
- IDLE:
  - load_start -> LOAD, index=0.
  - drain_start ignored.
- LOAD:
  - in_ready=1.
  - On in_valid: combinational ram_ce0=ram_we0=1, ram_address0=index, ram_d0=in_data; index++.
  - Accepting index AddressRange-1 -> LOADED, loaded=1, index=0.
  - Start pulses are ignored while in LOAD.
- LOADED:
  - drain_start -> DRAIN, index=0.
  - load_start -> LOAD, loaded=0, index=0. If both pulse in the same cycle, load_start wins.
- DRAIN:
  - ram_we0=0 always.
  - Issue a read (ram_ce0=1, ram_address0=index, index++) when index < AddressRange and (rd_pending=0 or out_ready=1).
  - rd_pending is set on issue and cleared on a handshake with no new issue.
  - out_valid=rd_pending. out_data=ram_q0. The RAM holds q0 while ce0=0, so a stalled output is stable.
  - Throughput: one element per cycle with out_ready held high. First out_valid appears 1 cycle after DRAIN entry.
  - out_last=rd_pending and (issued element index == AddressRange-1); track it with a last_pending flag.
  - Final handshake (out_last & out_ready) -> LOADED, done=1 for one cycle, loaded stays 1. A vector may be replayed any number of times.
  - Start pulses are ignored while in DRAIN.
- ram_ce0=0 in IDLE and LOADED; no spurious RAM accesses.
- Index width AddressWidth+1 to avoid wrap when AddressRange=2**AddressWidth.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, LOAD=1, LOADED=2, DRAIN=3);
  - default DataWidth/AddressWidth/AddressRange matching the temp-vector RAM.
- No sub-module needed; a single FSM plus an index counter.
- The bench instantiates mpc_mpc_dense_constraint_temp_V_RAM_AUTO_1R1W as the RAM model.

Test Plan:
- Load 1..6 with in_valid constant high, then drain_start with out_ready=1 -> writes at addresses 0..5 on 6 consecutive cycles. Output is 1,2,3,4,5,6 on 6 consecutive cycles, out_last on 6, done next cycle.
- Drain with out_ready toggling 1,0,0,1,... -> each value held stable while stalled. No duplicates or skips. ram_ce0 stays low during stalls.
- Load with in_valid gaps (valid on every 3rd cycle) -> in_ready high throughout, exactly 6 writes, loaded rises after the 6th write.
- Two back-to-back drains without reload -> identical sequences, two done pulses, loaded=1 throughout.
- Assert reset after the 3rd loaded element -> next cycle IDLE, loaded=0, in_ready=0. A new load of 7..12 then drains 7..12.
- load_start and drain_start in the same cycle in LOADED -> enters LOAD, loaded=0, no RAM read issued.

Source files
------------

// File: rtl/mpc_constraint_vec_port_master_pkg.sv
// Shared constants for the dense-constraint temp-vector port master.
package mpc_constraint_vec_port_master_pkg;

  // Defaults match the temp-vector RAM this block drives.
  localparam int unsigned DEF_DATA_WIDTH    = 21;
  localparam int unsigned DEF_ADDRESS_WIDTH = 3;
  localparam int unsigned DEF_ADDRESS_RANGE = 6;

  // Legacy-compatible state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_LOADED = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/mpc_constraint_vec_port_master_if.sv
// Control, upstream/downstream streams and RAM port of the vector port master.
interface mpc_constraint_vec_port_master_if #(
  parameter int unsigned DataWidth    = 21,
  parameter int unsigned AddressWidth = 3
);
  logic                    load_start;
  logic                    drain_start;
  logic [DataWidth-1:0]    in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DataWidth-1:0]    out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    loaded;
  logic                    busy;
  logic                    done;
  logic [AddressWidth-1:0] ram_address0;
  logic                    ram_ce0;
  logic                    ram_we0;
  logic [DataWidth-1:0]    ram_d0;
  logic [DataWidth-1:0]    ram_q0;

  modport master (
    input  load_start, drain_start, in_data, in_valid, out_ready, ram_q0,
    output in_ready, out_data, out_valid, out_last, loaded, busy, done,
           ram_address0, ram_ce0, ram_we0, ram_d0
  );

  modport slave (
    output load_start, drain_start, in_data, in_valid, out_ready, ram_q0,
    input  in_ready, out_data, out_valid, out_last, loaded, busy, done,
           ram_address0, ram_ce0, ram_we0, ram_d0
  );
endinterface

// File: rtl/mpc_mpc_dense_constraint_temp_V_RAM_AUTO_1R1W.sv
// Single-port temp-vector RAM: read-first, 1-cycle read latency, q0 holds while ce0=0.
module mpc_mpc_dense_constraint_temp_V_RAM_AUTO_1R1W #(
  parameter int unsigned DataWidth    = 21,
  parameter int unsigned AddressWidth = 3
) (
  input  logic                    clk,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  input  logic                    we0,
  input  logic [DataWidth-1:0]    d0,
  output logic [DataWidth-1:0]    q0
);
  logic [DataWidth-1:0] mem [0:(2**AddressWidth)-1];

  // Enabled access: old contents to q0, then optional write.
  always_ff @(posedge clk) begin
    if (ce0) begin
      q0 <= mem[address0];
      if (we0) mem[address0] <= d0;
    end
  end
endmodule

// File: rtl/mpc_constraint_vec_port_master.sv
// Loads a constraint vector into the temp RAM from a stream and replays it downstream.
module mpc_constraint_vec_port_master
  import mpc_constraint_vec_port_master_pkg::*;
#(
  parameter int unsigned DataWidth    = DEF_DATA_WIDTH,
  parameter int unsigned AddressWidth = DEF_ADDRESS_WIDTH,
  parameter int unsigned AddressRange = DEF_ADDRESS_RANGE
) (
  input logic clk,
  input logic reset,
  mpc_constraint_vec_port_master_if.master bus
);
  // One extra bit so the index can reach AddressRange without wrapping.
  localparam int unsigned IW = AddressWidth + 1;
  localparam logic [IW-1:0] RANGE_IDX = IW'(AddressRange);
  localparam logic [IW-1:0] LAST_IDX  = IW'(AddressRange - 1);

  logic [1:0]    state;
  logic [IW-1:0] index;
  logic          rd_pending;
  logic          last_pending;
  logic          loaded_r;
  logic          done_r;
  logic          wr_fire;
  logic          rd_issue;
  logic          out_fire;

  // Handshake qualifiers derived from state and stream inputs.
  always_comb begin
    wr_fire  = (state == ST_LOAD) && bus.in_valid;
    out_fire = (state == ST_DRAIN) && rd_pending && bus.out_ready;
    rd_issue = (state == ST_DRAIN) && (index < RANGE_IDX) && (!rd_pending || bus.out_ready);
  end

  // Output and RAM port drive; reads only issue in DRAIN, writes only in LOAD.
  always_comb begin
    bus.in_ready     = (state == ST_LOAD);
    bus.out_valid    = rd_pending;
    bus.out_last     = rd_pending && last_pending;
    bus.out_data     = bus.ram_q0;
    bus.loaded       = loaded_r;
    bus.busy         = (state == ST_LOAD) || (state == ST_DRAIN);
    bus.done         = done_r;
    bus.ram_ce0      = wr_fire || rd_issue;
    bus.ram_we0      = wr_fire;
    bus.ram_address0 = index[AddressWidth-1:0];
    bus.ram_d0       = bus.in_data;
  end

  // FSM, index counter and read-pipeline tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      rd_pending   <= 1'b0;
      last_pending <= 1'b0;
      loaded_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load_start) begin
            state <= ST_LOAD;
            index <= '0;
          end
        end
        ST_LOAD: begin
          if (wr_fire) begin
            if (index == LAST_IDX) begin
              state    <= ST_LOADED;
              loaded_r <= 1'b1;
              index    <= '0;
            end else begin
              index <= index + IW'(1);
            end
          end
        end
        ST_LOADED: begin
          if (bus.load_start) begin
            state    <= ST_LOAD;
            loaded_r <= 1'b0;
            index    <= '0;
          end else if (bus.drain_start) begin
            state        <= ST_DRAIN;
            index        <= '0;
            rd_pending   <= 1'b0;
            last_pending <= 1'b0;
          end
        end
        default: begin
          // A new issue while the output is consumed keeps rd_pending high,
          // so set-on-issue takes priority over clear-on-handshake.
          if (rd_issue) begin
            index        <= index + IW'(1);
            rd_pending   <= 1'b1;
            last_pending <= (index == LAST_IDX);
          end else if (out_fire) begin
            rd_pending   <= 1'b0;
            last_pending <= 1'b0;
          end
          if (out_fire && last_pending) begin
            state  <= ST_LOADED;
            done_r <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mpc_constraint_vec_port_master.sv
// Directed bench for the constraint-vector port master with the temp-vector RAM model.
module tb_mpc_constraint_vec_port_master;
  localparam int unsigned DW = 21;
  localparam int unsigned AW = 3;
  localparam int unsigned AR = 6;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mpc_constraint_vec_port_master_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  mpc_constraint_vec_port_master #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mpc_mpc_dense_constraint_temp_V_RAM_AUTO_1R1W #(
    .DataWidth(DW), .AddressWidth(AW)
  ) ram (
    .clk(clk), .address0(bus.ram_address0), .ce0(bus.ram_ce0),
    .we0(bus.ram_we0), .d0(bus.ram_d0), .q0(bus.ram_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic pulse_load();
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_drain();
    @(negedge clk);
    bus.drain_start = 1'b1;
    @(negedge clk);
    bus.drain_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.loaded !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL reset_status busy=%b loaded=%b done=%b expected 0/0/0", bus.busy, bus.loaded, bus.done);
    end
    tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.ram_ce0 !== 1'b0) begin
      fails++; $display("FAIL reset_outputs in_ready=%b out_valid=%b out_last=%b ce0=%b expected all 0",
                        bus.in_ready, bus.out_valid, bus.out_last, bus.ram_ce0);
    end
    // drain_start in IDLE must be ignored
    pulse_drain();
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.ram_ce0 !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL idle_drain_ignored busy=%b ce0=%b out_valid=%b expected 0/0/0", bus.busy, bus.ram_ce0, bus.out_valid);
    end
  endtask

  task automatic test_load(input int base);
    pulse_load();
    for (int i = 0; i < int'(AR); i++) begin
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_data     = DW'(base + i);
      bus.drain_start = (i == 2);
      bus.load_start  = (i == 3);
      #1;
      tests++; if (bus.in_ready !== 1'b1 || bus.ram_ce0 !== 1'b1 || bus.ram_we0 !== 1'b1 ||
                   bus.ram_address0 !== AW'(i) || bus.ram_d0 !== DW'(base + i) || bus.loaded !== 1'b0) begin
        fails++; $display("FAIL load_write[%0d] rdy=%b ce=%b we=%b addr=%0d d=%0d loaded=%b expected 1/1/1/%0d/%0d/0",
                          i, bus.in_ready, bus.ram_ce0, bus.ram_we0, bus.ram_address0, bus.ram_d0, bus.loaded, i, base + i);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.drain_start = 1'b0; bus.load_start = 1'b0;
    #1;
    tests++; if (bus.loaded !== 1'b1 || bus.busy !== 1'b0 || bus.ram_ce0 !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL load_complete loaded=%b busy=%b ce0=%b in_ready=%b expected 1/0/0/0",
                        bus.loaded, bus.busy, bus.ram_ce0, bus.in_ready);
    end
  endtask

  task automatic test_drain(input int base);
    bus.out_ready = 1'b1;
    pulse_drain();
    #1;
    tests++; if (bus.ram_ce0 !== 1'b1 || bus.ram_we0 !== 1'b0 || bus.ram_address0 !== '0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL drain_first_issue ce=%b we=%b addr=%0d out_valid=%b expected 1/0/0/0",
                        bus.ram_ce0, bus.ram_we0, bus.ram_address0, bus.out_valid);
    end
    for (int i = 0; i < int'(AR); i++) begin
      @(negedge clk);
      #1;
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(base + i) || bus.out_last !== (i == int'(AR) - 1) ||
                   bus.ram_ce0 !== (i < int'(AR) - 1) || bus.ram_we0 !== 1'b0 || bus.loaded !== 1'b1 || bus.done !== 1'b0) begin
        fails++; $display("FAIL drain_elem[%0d] valid=%b data=%0d last=%b ce=%b we=%b loaded=%b done=%b expected data=%0d",
                          i, bus.out_valid, bus.out_data, bus.out_last, bus.ram_ce0, bus.ram_we0, bus.loaded, bus.done, base + i);
      end
    end
    @(negedge clk);
    #1;
    tests++; if (bus.done !== 1'b1 || bus.loaded !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL drain_done done=%b loaded=%b busy=%b out_valid=%b expected 1/1/0/0",
                        bus.done, bus.loaded, bus.busy, bus.out_valid);
    end
    @(negedge clk);
    #1;
    tests++; if (bus.done !== 1'b0 || bus.ram_ce0 !== 1'b0) begin
      fails++; $display("FAIL done_pulse_width done=%b ce0=%b expected 0/0", bus.done, bus.ram_ce0);
    end
  endtask

  task automatic test_drain_stall(input int base);
    int  e;
    bit  got_done;
    e = 0;
    got_done = 1'b0;
    bus.out_ready = 1'b1;
    pulse_drain();
    for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
      @(negedge clk);
      bus.out_ready = ((cyc % 3) == 0);
      #1;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
      end else if (bus.out_valid === 1'b1) begin
        tests++; if (bus.out_data !== DW'(base + e) || bus.out_last !== (e == int'(AR) - 1)) begin
          fails++; $display("FAIL stall_elem[%0d] data=%0d last=%b expected %0d/%b",
                            e, bus.out_data, bus.out_last, base + e, e == int'(AR) - 1);
        end
        if (bus.out_ready) begin
          e++;
        end else begin
          tests++; if (bus.ram_ce0 !== 1'b0) begin
            fails++; $display("FAIL stall_ce0 ce0=%b expected 0 while stalled at elem %0d", bus.ram_ce0, e);
          end
        end
      end
    end
    bus.out_ready = 1'b1;
    tests++; if (!got_done || e != int'(AR)) begin
      fails++; $display("FAIL stall_count done_seen=%b delivered=%0d expected 1/%0d", got_done, e, AR);
    end
  endtask

  task automatic test_load_gaps(input int base);
    int w;
    w = 0;
    pulse_load();
    for (int cyc = 0; cyc < 40 && w < int'(AR); cyc++) begin
      @(negedge clk);
      bus.in_valid = ((cyc % 3) == 2);
      bus.in_data  = DW'(base + w);
      #1;
      tests++; if (bus.in_ready !== 1'b1 || bus.loaded !== 1'b0) begin
        fails++; $display("FAIL gap_ready cyc=%0d in_ready=%b loaded=%b expected 1/0", cyc, bus.in_ready, bus.loaded);
      end
      if (bus.in_valid) begin
        tests++; if (bus.ram_ce0 !== 1'b1 || bus.ram_we0 !== 1'b1 || bus.ram_address0 !== AW'(w)) begin
          fails++; $display("FAIL gap_write[%0d] ce=%b we=%b addr=%0d expected 1/1/%0d", w, bus.ram_ce0, bus.ram_we0, bus.ram_address0, w);
        end
        w++;
      end else begin
        tests++; if (bus.ram_ce0 !== 1'b0) begin
          fails++; $display("FAIL gap_idle_ce0 cyc=%0d ce0=%b expected 0", cyc, bus.ram_ce0);
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    tests++; if (w != int'(AR) || bus.loaded !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL gap_complete writes=%0d loaded=%b in_ready=%b expected %0d/1/0", w, bus.loaded, bus.in_ready, AR);
    end
  endtask

  task automatic test_back_to_back(input int base);
    test_drain(base);
    tests++; if (bus.loaded !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL b2b_between loaded=%b busy=%b expected 1/0", bus.loaded, bus.busy);
    end
    test_drain(base);
  endtask

  task automatic test_reset_midload();
    pulse_load();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(100 + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.loaded !== 1'b0 || bus.in_ready !== 1'b0 || bus.ram_ce0 !== 1'b0) begin
      fails++; $display("FAIL midload_reset busy=%b loaded=%b in_ready=%b ce0=%b expected 0/0/0/0",
                        bus.busy, bus.loaded, bus.in_ready, bus.ram_ce0);
    end
    test_load(7);
    test_drain(7);
  endtask

  task automatic test_both_pulse();
    @(negedge clk);
    bus.load_start  = 1'b1;
    bus.drain_start = 1'b1;
    #1;
    tests++; if (bus.ram_ce0 !== 1'b0) begin
      fails++; $display("FAIL both_pulse_ce0 ce0=%b expected 0", bus.ram_ce0);
    end
    @(negedge clk);
    bus.load_start  = 1'b0;
    bus.drain_start = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.loaded !== 1'b0 || bus.ram_ce0 !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL both_pulse_load busy=%b in_ready=%b loaded=%b ce0=%b out_valid=%b expected 1/1/0/0/0",
                        bus.busy, bus.in_ready, bus.loaded, bus.ram_ce0, bus.out_valid);
    end
    @(negedge clk);
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.ram_ce0 !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL both_pulse_noread out_valid=%b ce0=%b in_ready=%b expected 0/0/1",
                        bus.out_valid, bus.ram_ce0, bus.in_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.load_start  = 1'b0;
    bus.drain_start = 1'b0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    test_reset();
    test_load(1);
    test_drain(1);
    test_drain_stall(1);
    test_load_gaps(11);
    test_back_to_back(11);
    test_reset_midload();
    test_both_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
